// File: rtl/switch_debounce_port.sv
// Memory-mapped switch input port: 2-flop synchroniser, per-bit debounce,
// sticky write-1-to-clear change flags and a level interrupt, all on the falling clock edge.
`timescale 1ns/1ps
module switch_debounce_port #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 20,
  parameter int EDGE_MODE = 0
) (
  input  logic             switclk,
  input  logic             switrst,
  input  logic             switcs,
  input  logic             switread,
  input  logic             switwrite,
  input  logic [1:0]       switchaddr,
  input  logic [31:0]      switch_wmask,
  input  logic [WIDTH-1:0] switch_rdata,
  output logic [31:0]      switch_wdata,
  output logic             switch_irq
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_LO    = 2'b00,
    ADDR_WORD  = 2'b01,
    ADDR_HI    = 2'b10,
    ADDR_FLAGS = 2'b11
  } addr_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [31:0]      wdata_q, wdata_d;

  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [31:0]      stable_ext, flags_ext;
  addr_e            addr;
  logic             unused_wmask;

  assign addr         = addr_e'(switchaddr);
  assign unused_wmask = ^switch_wmask;

  // Debounce: a bit must disagree with its stable value for DB_CYCLES
  // consecutive edges; any agreement in between restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ev = '0;
    case (EDGE_MODE)
      1:       ev = stable_d & ~stable_q;
      2:       ev = ~stable_d & stable_q;
      default: ev = stable_d ^ stable_q;
    endcase
  end

  // A new event outranks a clear of the same bit in the same cycle.
  always_comb begin
    clr = '0;
    if (switcs && switwrite && addr == ADDR_FLAGS) begin
      clr = switch_wmask[WIDTH-1:0];
    end
    flags_d = (flags_q & ~clr) | ev;
  end

  always_comb begin
    stable_ext            = '0;
    stable_ext[WIDTH-1:0] = stable_q;
    flags_ext             = '0;
    flags_ext[WIDTH-1:0]  = flags_q;
    wdata_d               = wdata_q;
    if (switcs && switread) begin
      case (addr)
        ADDR_LO:    wdata_d = {24'b0, stable_q[7:0]};
        ADDR_WORD:  wdata_d = stable_ext;
        ADDR_HI:    wdata_d = {24'b0, stable_q[15:8]};
        ADDR_FLAGS: wdata_d = flags_ext;
        default:    wdata_d = wdata_q;
      endcase
    end
  end

  always_ff @(negedge switclk or posedge switrst) begin
    if (switrst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      flags_q  <= '0;
      wdata_q  <= '0;
      // NOTE: cnt is a small register array, not a RAM, so it is reset like every other flop.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, which the synchroniser chain depends on.
      sync1_q  <= switch_rdata;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      flags_q  <= flags_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign switch_wdata = wdata_q;
  assign switch_irq   = |flags_q;

endmodule

// File: tb/tb_switch_debounce_port.sv
// Directed bench for switch_debounce_port: three instances (edge modes 0/1/2)
// share the same bus and pins; inputs change at posedge, outputs are checked away from the falling edge.
`timescale 1ns/1ps
module tb_switch_debounce_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [31:0] wmask = '0;
  logic [15:0] pins = '0;

  logic [31:0] wdata0, wdata_r, wdata_f;
  logic        irq0, irq_r, irq_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debounce_port #(.WIDTH(16), .DB_CYCLES(4), .EDGE_MODE(0)) u_dut (
    .switclk(clk), .switrst(rst), .switcs(cs), .switread(rd_s), .switwrite(wr_s),
    .switchaddr(addr), .switch_wmask(wmask), .switch_rdata(pins),
    .switch_wdata(wdata0), .switch_irq(irq0));

  switch_debounce_port #(.WIDTH(16), .DB_CYCLES(4), .EDGE_MODE(1)) u_dut_r (
    .switclk(clk), .switrst(rst), .switcs(cs), .switread(rd_s), .switwrite(wr_s),
    .switchaddr(addr), .switch_wmask(wmask), .switch_rdata(pins),
    .switch_wdata(wdata_r), .switch_irq(irq_r));

  switch_debounce_port #(.WIDTH(16), .DB_CYCLES(4), .EDGE_MODE(2)) u_dut_f (
    .switclk(clk), .switrst(rst), .switcs(cs), .switread(rd_s), .switwrite(wr_s),
    .switchaddr(addr), .switch_wmask(wmask), .switch_rdata(pins),
    .switch_wdata(wdata_f), .switch_irq(irq_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    cs = 1'b1; rd_s = 1'b1; addr = a;
    @(posedge clk);
    cs = 1'b0; rd_s = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic sel, input logic [31:0] m);
    cs = sel; wr_s = 1'b1; addr = a; wmask = m;
    @(posedge clk);
    cs = 1'b0; wr_s = 1'b0; wmask = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    step(3);
    check("por_wdata", wdata0, 32'h0);
    check("por_irq", {31'b0, irq0}, 32'h0);
    rst = 1'b0;
    step(2);

    // Clean change: stable and flag update at E5
    pins = 16'h00A5;
    step(5);
    check("clean_irq_before_e5", {31'b0, irq0}, 32'h0);
    step(1);
    check("clean_irq_at_e5", {31'b0, irq0}, 32'h1);
    check("clean_irq_rise_mode", {31'b0, irq_r}, 32'h1);
    check("clean_irq_fall_mode", {31'b0, irq_f}, 32'h0);
    rd(2'b00); check("clean_rd00", wdata0, 32'h0000_00A5);
    rd(2'b10); check("clean_rd10", wdata0, 32'h0);
    rd(2'b01); check("clean_rd01", wdata0, 32'h0000_00A5);
    rd(2'b11);
    check("clean_flags", wdata0, 32'h0000_00A5);
    check("clean_flags_rise", wdata_r, 32'h0000_00A5);
    check("clean_flags_fall", wdata_f, 32'h0);
    // Read strobe without chip-select must not update read data
    rd_s = 1'b1; addr = 2'b10;
    step(1);
    rd_s = 1'b0;
    check("read_no_cs_hold", wdata0, 32'h0000_00A5);
    wr(2'b11, 1'b1, 32'h0000_FFFF);
    check("clear_all_irq", {31'b0, irq0}, 32'h0);

    // Clear scenario: flags 0011, clear bit 0, then collide clear with a new bit-4 event
    pins = 16'h00B4;
    step(6);
    rd(2'b11); check("clr_flags_0011", wdata0, 32'h0000_0011);
    wr(2'b11, 1'b1, 32'h0000_0001);
    rd(2'b11); check("clr_bit0", wdata0, 32'h0000_0010);
    check("clr_bit0_irq", {31'b0, irq0}, 32'h1);
    pins = 16'h00A4;
    step(5);
    wr(2'b11, 1'b1, 32'h0000_0010);
    rd(2'b11); check("set_beats_clear", wdata0, 32'h0000_0010);
    check("set_beats_clear_irq", {31'b0, irq0}, 32'h1);
    wr(2'b11, 1'b1, 32'h0000_FFFF);
    check("clear_again_irq", {31'b0, irq0}, 32'h0);

    // Bounce on bit 3: 3 high, 1 low, five times, then hold high
    for (int k = 0; k < 5; k++) begin
      pins = 16'h00AC;
      step(3);
      pins = 16'h00A4;
      step(1);
    end
    check("bounce_no_accept", {31'b0, irq0}, 32'h0);
    pins = 16'h00AC;
    step(5);
    check("bounce_hold_before", {31'b0, irq0}, 32'h0);
    step(1);
    check("bounce_hold_accept", {31'b0, irq0}, 32'h1);
    rd(2'b11); check("bounce_one_flag", wdata0, 32'h0000_0008);
    rd(2'b00); check("bounce_rd00", wdata0, 32'h0000_00AC);
    wr(2'b11, 1'b1, 32'h0000_FFFF);

    // Edge modes: bit 0 rises, then falls
    pins = 16'h00AD;
    step(6);
    check("rise_irq_any", {31'b0, irq0}, 32'h1);
    check("rise_irq_rmode", {31'b0, irq_r}, 32'h1);
    check("rise_irq_fmode", {31'b0, irq_f}, 32'h0);
    rd(2'b11);
    check("rise_flags_rmode", wdata_r, 32'h0000_0001);
    check("rise_flags_fmode", wdata_f, 32'h0);
    wr(2'b11, 1'b1, 32'h0000_FFFF);
    pins = 16'h00AC;
    step(6);
    check("fall_irq_any", {31'b0, irq0}, 32'h1);
    check("fall_irq_rmode", {31'b0, irq_r}, 32'h0);
    check("fall_irq_fmode", {31'b0, irq_f}, 32'h1);
    rd(2'b11);
    check("fall_flags_rmode", wdata_r, 32'h0);
    check("fall_flags_fmode", wdata_f, 32'h0000_0001);
    wr(2'b11, 1'b1, 32'h0000_FFFF);

    // Ignored writes, then read/clear collision with flags 8000
    pins = 16'h80AC;
    step(6);
    wr(2'b01, 1'b1, 32'h0000_FFFF);
    wr(2'b11, 1'b0, 32'h0000_FFFF);
    check("ignored_writes_irq", {31'b0, irq0}, 32'h1);
    rd(2'b11); check("ignored_writes_flags", wdata0, 32'h0000_8000);
    cs = 1'b1; rd_s = 1'b1; wr_s = 1'b1; addr = 2'b11; wmask = 32'h0000_FFFF;
    step(1);
    cs = 1'b0; rd_s = 1'b0; wr_s = 1'b0; wmask = '0;
    check("collide_rdata", wdata0, 32'h0000_8000);
    check("collide_irq", {31'b0, irq0}, 32'h0);
    rd(2'b11); check("collide_flags_after", wdata0, 32'h0);

    // Reset asserted mid-debounce, then post-reset debounce of high pins
    pins = 16'hFFFF;
    step(6);
    rd(2'b01); check("pre_reset_rd01", wdata0, 32'h0000_FFFF);
    check("pre_reset_irq", {31'b0, irq0}, 32'h1);
    pins = 16'h0000;
    step(3);
    #2 rst = 1'b1;
    #1;
    check("rst_wdata", wdata0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    check("rst_irq_rmode", {31'b0, irq_r}, 32'h0);
    pins = 16'hFFFF;
    step(2);
    check("rst_hold_wdata", wdata0, 32'h0);
    #2 rst = 1'b0;
    rd(2'b01); check("post_rst_rd_e0", wdata0, 32'h0);
    step(4);
    rd(2'b01); check("post_rst_rd_e5", wdata0, 32'h0);
    check("post_rst_irq_e5", {31'b0, irq0}, 32'h1);
    rd(2'b01); check("post_rst_rd_e6", wdata0, 32'h0000_FFFF);
    rd(2'b11);
    check("post_rst_flags", wdata0, 32'h0000_FFFF);
    check("post_rst_flags_rmode", wdata_r, 32'h0000_FFFF);
    check("post_rst_flags_fmode", wdata_f, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debounce_port.md
# switch_debounce_port

Parametrised successor to the board switch input port: memory-mapped input block between the EGO1 switch pins and the CPU's MemOrIO bus. Each of `WIDTH` raw switch inputs passes through a 2-flop synchroniser and a per-bit debounce counter. The block keeps sticky, write-1-to-clear change flags with a selectable edge mode and a level interrupt output. The CPU reads the debounced value, either as byte lanes or as the full word, plus the flag register through a 2-bit sub-address.

## Interface
- `WIDTH`, 16 — number of switch inputs; legal range 16..32.
- `DB_CYCLES`, 20 — consecutive `switclk` cycles a synchronised bit must differ from its stable value before the change is accepted; ≥2.
- `EDGE_MODE`, 0 — flag source: 0 = any change, 1 = rising (0→1) only, 2 = falling (1→0) only.

- `switclk`  in  1  block clock; all sequential logic on falling edge.
- `switrst`  in  1  reset; asynchronous, active-high.
- `switcs`  in  1  chip-select from MemOrIO.
- `switread`  in  1  read strobe.
- `switwrite`  in  1  write strobe (flag clear only).
- `switchaddr`  in  2  register select.
- `switch_wmask`  in  32  write data; bit i = 1 clears flag i.
- `switch_rdata`  in  WIDTH  raw, asynchronous switch pins.
- `switch_wdata`  out  32  read data to CPU, registered.
- `switch_irq`  out  1  OR of all change flags.

## Operation
- Synchroniser: `sync1 <= switch_rdata`, `sync2 <= sync1` each falling edge.
- Debounce, per bit i, with `cnt[i]` of width clog2(DB_CYCLES):
  - `sync2[i] == stable[i]`: `cnt[i] <= 0`.
  - Differs and `cnt[i] == DB_CYCLES-1`: `stable[i] <= sync2[i]`, `cnt[i] <= 0`.
  - Differs otherwise: `cnt[i] <= cnt[i]+1`.
  - A bounce back to `stable[i]` before the count completes restarts the count; no partial credit.
- Change detect: `ev[i]` is high in the cycle `stable[i]` toggles, qualified by `EDGE_MODE`.
  - Update: `flags <= (flags & ~clr) | ev`.
  - `clr = switch_wmask[WIDTH-1:0]` when `switcs && switwrite && switchaddr==2'b11`, else 0.
  - A set in the same cycle as a clear of the same bit wins; the flag stays 1.
- Read register, when `switcs && switread`:
  - `00`: `{24'b0, stable[7:0]}`.
  - `01`: `stable` zero-extended to 32 bits.
  - `10`: `{24'b0, stable[15:8]}`.
  - `11`: `flags` zero-extended to 32 bits.
  - When not reading, `switch_wdata` holds its value.
- Read and write-clear of `11` in the same cycle: read returns pre-clear flags.
- Writes to `00`/`01`/`10` are ignored. `switwrite` without `switcs` is ignored.
- `switch_irq = |flags`; combinational from the flag register only.

## Timing
- Reset (async assert, any time, including mid-debounce or mid-read): `sync1`, `sync2`, `stable`, every `cnt`, `flags`, `switch_wdata` = 0; `switch_irq` = 0. Operation resumes on the first falling edge after deassert.
- Post-reset boundary: pins held high at reset exit produce a normal debounce, and in mode 0/1 set their flags. This is required; software clears them.
- Pin-to-stable latency: pin steady before falling edge E0 → `sync2` updates at E1 → `stable` updates at E(1+DB_CYCLES).
- Flag sets at the same edge `stable` changes. `switch_irq` rises right after that edge.
- Read latency: strobe sampled at falling edge; `switch_wdata` is valid from that edge and is held for the CPU's following rising edge.
- Counter never exceeds `DB_CYCLES-1`; no wrap-around.
- Bits ≥ WIDTH in any read or mask are 0 or ignored.

## Test plan
Conditions for all scenarios: WIDTH=16, DB_CYCLES=4.
- Reset: raise `switrst` mid-count with `switch_rdata=16'hFFFF`, read `01` after release → 0 until debounce completes; `switch_wdata=0` and `switch_irq=0` during reset.
- Clean change: set `switch_rdata=16'h00A5` before E0 → `stable` updates at E5. Read `00` → `32'h000000A5`; read `10` → 0; `flags=16'h00A5` (mode 0); `switch_irq=1`.
- Bounce: toggle bit 3 for 3 cycles, back for 1, repeat ×5, then hold high → `stable[3]` changes only 4 cycles after the final hold; exactly one flag set.
- Edge modes: EDGE_MODE=1, bit 0 goes 0→1→0 (each debounced) → flag set only on rise. EDGE_MODE=2, same stimulus → flag set only on fall.
- Clear: flags=`16'h0011`, write `11` with mask `32'h00000001` → flags `16'h0010`, `switch_irq` stays 1. Then clear bit 4 in the same cycle bit 4's stable value toggles → flag 4 remains 1.
- Read/clear collision: read and write `11` (mask `32'hFFFF`) simultaneously with flags `16'h8000` → `switch_wdata=32'h00008000`, next cycle flags=0 and `switch_irq=0`.
